stream_serializer: RTL

STREAM_SERIALIZER -- requirements
Module: stream_serializer

---
 rtl/stream_serializer_pkg.sv | 12 +
 rtl/stream_serializer.sv | 110 +++++++++++
 2 files changed

// File: rtl/stream_serializer_pkg.sv
// Shared types for the stream serializer: the holding-register occupancy state.
// Pure type definitions, no logic.
// Imported by stream_serializer.
package stream_serializer_pkg;

  // Occupancy of the one-word holding register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ser_state_e;

endpackage

// File: rtl/stream_serializer.sv
// Purpose: splits a wide word of NumLanes lanes into num+1 single-lane beats, lane 0 first.
// Latency: first lane valid the cycle after the src handshake; sustained num+1 cycles per word.
// Backpressure: holds the current lane while dst_ready_i is low; src_ready_o only while empty or on the last-lane handshake.
// Optional: define STREAM_SERIALIZER_LAST_EN to add the dst_last_o end-of-word marker port.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter type         T        = logic,
  parameter int unsigned NumLanes = 2,
  localparam int unsigned LenWidth = (NumLanes > 2) ? $clog2(NumLanes) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                src_valid_i,
  output logic                src_ready_o,
  input  T [NumLanes-1:0]     src_data_i,
  input  logic [LenWidth-1:0] src_num_i,
  output logic                dst_valid_o,
  input  logic                dst_ready_i,
  output T                    dst_data_o
`ifdef STREAM_SERIALIZER_LAST_EN
  ,
  output logic                dst_last_o
`endif
);

  localparam logic [LenWidth-1:0] MaxNum = LenWidth'(NumLanes - 1);

  ser_state_e          state_q, state_d;
  T [NumLanes-1:0]     data_q, data_d;
  logic [LenWidth-1:0] num_q, num_d;
  logic [LenWidth-1:0] idx_q, idx_d;
  logic [LenWidth-1:0] num_clamped;
  logic                last_lane;
  logic                src_hs;
  logic                dst_hs;

  // Requests for more lanes than exist collapse to the full word.
  assign num_clamped = (src_num_i > MaxNum) ? MaxNum : src_num_i;

  assign last_lane   = (idx_q == num_q);
  assign dst_valid_o = (state_q == ST_FULL);
  // Refill is allowed in the same cycle the last lane leaves, so words stream with no bubble.
  assign src_ready_o = (state_q == ST_EMPTY) || (dst_ready_i && last_lane);
  assign src_hs      = src_valid_i && src_ready_o;
  assign dst_hs      = dst_valid_o && dst_ready_i;

  // With a single lane the index never moves, so the select collapses to lane 0.
  if (NumLanes == 1) begin : g_one_lane
    assign dst_data_o = data_q[0];
  end else begin : g_multi_lane
    assign dst_data_o = data_q[idx_q];
  end

`ifdef STREAM_SERIALIZER_LAST_EN
  assign dst_last_o = dst_valid_o && last_lane;
`endif

  // Next-state: load a new word on src handshake, otherwise step or retire on dst handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    num_d   = num_q;
    idx_d   = idx_q;
    if (src_hs) begin
      state_d = ST_FULL;
      data_d  = src_data_i;
      num_d   = num_clamped;
      idx_d   = '0;
    end else if (dst_hs) begin
      if (last_lane) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + LenWidth'(1);
      end
    end
  end

  // State and holding register; reset drops any partly emitted word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
    end
  end

`ifndef COMMON_CELLS_ASSERTS_OFF
  // Output beat must not change while stalled.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dst_valid_o && !dst_ready_i) |=> (dst_valid_o && $stable(dst_data_o)));
`ifdef STREAM_SERIALIZER_LAST_EN
  // End-of-word marker must not change while stalled.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dst_valid_o && !dst_ready_i) |=> $stable(dst_last_o));
`endif
  // Upstream must hold an offered word until it is taken.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (src_valid_i && !src_ready_o) |=>
      (src_valid_i && $stable(src_data_i) && $stable(src_num_i)));
`endif

endmodule
